// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, IR field positions,
// sequencer states and the decoded-opcode bundles.
package cpu_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [2:0] {
    IDLE,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
    HALT
  } state_t;

  typedef struct packed {
    logic op_add;
    logic op_sub;
    logic op_mul;
    logic op_div;
    logic op_shr;
    logic op_shl;
    logic op_ror;
    logic op_rol;
    logic op_and;
    logic op_or;
    logic op_negate;
    logic op_not;
  } alu_ops_t;

  typedef struct packed {
    logic alu;
    logic muldiv;
    logic unary;
    logic io_in;
    logic io_out;
    logic nop;
    logic halt;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/op_decoder.sv
// Combinational opcode decode: one ALU strobe (at most) plus exactly one class flag.
module op_decoder
  import cpu_pkg::*;
(
  input  logic [4:0] opcode_i,
  output alu_ops_t   ops_o,
  output op_class_t  cls_o
);

  always_comb begin
    ops_o = '0;
    cls_o = '0;
    unique case (opcode_i)
      OP_ADD:  begin ops_o.op_add    = 1'b1; cls_o.alu    = 1'b1; end
      OP_SUB:  begin ops_o.op_sub    = 1'b1; cls_o.alu    = 1'b1; end
      OP_SHR:  begin ops_o.op_shr    = 1'b1; cls_o.alu    = 1'b1; end
      OP_SHL:  begin ops_o.op_shl    = 1'b1; cls_o.alu    = 1'b1; end
      OP_ROR:  begin ops_o.op_ror    = 1'b1; cls_o.alu    = 1'b1; end
      OP_ROL:  begin ops_o.op_rol    = 1'b1; cls_o.alu    = 1'b1; end
      OP_AND:  begin ops_o.op_and    = 1'b1; cls_o.alu    = 1'b1; end
      OP_OR:   begin ops_o.op_or     = 1'b1; cls_o.alu    = 1'b1; end
      OP_MUL:  begin ops_o.op_mul    = 1'b1; cls_o.muldiv = 1'b1; end
      OP_DIV:  begin ops_o.op_div    = 1'b1; cls_o.muldiv = 1'b1; end
      OP_NEG:  begin ops_o.op_negate = 1'b1; cls_o.unary  = 1'b1; end
      OP_NOT:  begin ops_o.op_not    = 1'b1; cls_o.unary  = 1'b1; end
      OP_IN:   cls_o.io_in  = 1'b1;
      OP_OUT:  cls_o.io_out = 1'b1;
      OP_NOP:  cls_o.nop    = 1'b1;
      OP_HALT: cls_o.halt   = 1'b1;
      default: cls_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state sequencer for the single-bus datapath: fetch with memory wait
// states, decode of the live IR, and execute; strobes decode from the registered state.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int BITS       = 32,
  parameter int REGISTERS  = 16,
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 mem_ready,
  input  logic [BITS-1:0]      IRVal,
  output logic [REGISTERS-1:0] GPRin,
  output logic [REGISTERS-1:0] GPRout,
  output logic                 PCin,
  output logic                 IRin,
  output logic                 RYin,
  output logic                 RZin,
  output logic                 MARin,
  output logic                 HILOin,
  output logic                 MDRin,
  output logic                 OUTPUTin,
  output logic                 Read,
  output logic                 Write,
  output logic                 INPUTout,
  output logic                 MDRout,
  output logic                 HILOout,
  output logic                 RZout,
  output logic                 PCout,
  output logic                 BAout,
  output logic                 ADD,
  output logic                 SUB,
  output logic                 MUL,
  output logic                 DIV,
  output logic                 SHR,
  output logic                 SHL,
  output logic                 ROR,
  output logic                 ROL,
  output logic                 AND,
  output logic                 OR,
  output logic                 NEGATE,
  output logic                 NOT,
  output logic                 IncPC,
  output logic                 halted,
  output logic                 illegal,
  output logic                 instr_done
);

  localparam int MAX_HOLD = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  alu_ops_t   ops;
  op_class_t  cls;
  logic       uses_ra, uses_rb, uses_rc;
  logic       reg_bad, legal;
  logic       op_en, done;
  logic [CNT_W-1:0] hold_last;
  logic       ir_unused;

  assign opcode = IRVal[OPC_HI:OPC_LO];
  assign ra     = IRVal[RA_HI:RA_LO];
  assign rb     = IRVal[RB_HI:RB_LO];
  assign rc     = IRVal[RC_HI:RC_LO];
  assign ir_unused = ^IRVal;

  op_decoder u_dec (
    .opcode_i (opcode),
    .ops_o    (ops),
    .cls_o    (cls)
  );

  function automatic logic bad_idx(input logic [3:0] idx);
    return int'(idx) >= REGISTERS;
  endfunction

  function automatic logic [REGISTERS-1:0] sel(input logic [3:0] idx);
    logic [REGISTERS-1:0] v;
    v = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (int'(idx) == i) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Only the fields an opcode actually uses can make it illegal.
  assign uses_ra = cls.alu | cls.unary | cls.io_in | cls.io_out;
  assign uses_rb = cls.alu | cls.muldiv | cls.unary;
  assign uses_rc = cls.alu | cls.muldiv;
  assign reg_bad = (uses_ra & bad_idx(ra)) | (uses_rb & bad_idx(rb)) | (uses_rc & bad_idx(rc));
  assign legal   = ~cls.illegal & ~reg_bad;

  assign hold_last = ops.op_mul ? MUL_LAST : DIV_LAST;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_en      = 1'b0;
    done       = 1'b0;
    GPRin      = '0;
    GPRout     = '0;
    PCin       = 1'b0;
    IRin       = 1'b0;
    RYin       = 1'b0;
    RZin       = 1'b0;
    MARin      = 1'b0;
    HILOin     = 1'b0;
    MDRin      = 1'b0;
    OUTPUTin   = 1'b0;
    Read       = 1'b0;
    INPUTout   = 1'b0;
    MDRout     = 1'b0;
    HILOout    = 1'b0;
    RZout      = 1'b0;
    PCout      = 1'b0;
    IncPC      = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    instr_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) state_d = T0;
      end
      T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        RZin    = 1'b1;
        state_d = T1;
      end
      T1: begin
        // RZ is not reloaded here, so holding PCin across wait states is harmless.
        RZout = 1'b1;
        PCin  = 1'b1;
        Read  = 1'b1;
        MDRin = 1'b1;
        if (mem_ready) state_d = T2;
      end
      T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = T3;
      end
      T3: begin
        if (!legal) begin
          illegal = 1'b1;
          done    = 1'b1;
        end else if (cls.alu || cls.muldiv) begin
          GPRout  = sel(rb);
          RYin    = 1'b1;
          cnt_d   = '0;
          state_d = T4;
        end else if (cls.unary) begin
          GPRout  = sel(rb);
          op_en   = 1'b1;
          RZin    = 1'b1;
          state_d = T5;
        end else if (cls.io_in) begin
          INPUTout = 1'b1;
          GPRin    = sel(ra);
          done     = 1'b1;
        end else if (cls.io_out) begin
          GPRout   = sel(ra);
          OUTPUTin = 1'b1;
          done     = 1'b1;
        end else if (cls.halt) begin
          state_d = HALT;
        end else begin
          done = 1'b1;
        end
      end
      T4: begin
        GPRout = sel(rc);
        op_en  = 1'b1;
        RZin   = 1'b1;
        if (cls.muldiv && (cnt_q != hold_last)) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = T5;
        end
      end
      T5: begin
        RZout = 1'b1;
        if (cls.muldiv) HILOin = 1'b1;
        else            GPRin  = sel(ra);
        done = 1'b1;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      instr_done = 1'b1;
      state_d    = run ? T0 : IDLE;
    end
  end

  assign ADD    = op_en & ops.op_add;
  assign SUB    = op_en & ops.op_sub;
  assign MUL    = op_en & ops.op_mul;
  assign DIV    = op_en & ops.op_div;
  assign SHR    = op_en & ops.op_shr;
  assign SHL    = op_en & ops.op_shl;
  assign ROR    = op_en & ops.op_ror;
  assign ROL    = op_en & ops.op_rol;
  assign AND    = op_en & ops.op_and;
  assign OR     = op_en & ops.op_or;
  assign NEGATE = op_en & ops.op_negate;
  assign NOT    = op_en & ops.op_not;

  // Kept only for port compatibility with the datapath.
  assign Write = 1'b0;
  assign BAout = 1'b0;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed + randomized instruction streams; each cycle's strobes are compared with a
// per-instruction micro-program expanded from the opcode rules.
module tb_control_sequencer;

  localparam int MULC = 4;
  localparam int DIVC = 3;

  typedef struct packed {
    logic [15:0] gin;
    logic [15:0] gout;
    logic pc_in, ir_in, ry_in, rz_in, mar_in, hilo_in, mdr_in, out_in, rd, wr;
    logic in_out, mdr_out, hilo_out, rz_out, pc_out, ba_out;
    logic add, sub, mul, div, shr, shl, ror, rol, and_, or_, neg, not_, inc_pc;
    logic halted, illegal, done;
  } ctl_t;

  typedef struct {
    logic        rdy;
    logic        run;
    logic [31:0] ir;
    ctl_t        exp;
    int          id;
  } cyc_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] IRVal = '0;
  logic [15:0] GPRin, GPRout;
  logic PCin, IRin, RYin, RZin, MARin, HILOin, MDRin, OUTPUTin, Read, Write;
  logic INPUTout, MDRout, HILOout, RZout, PCout, BAout;
  logic ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC;
  logic halted, illegal, instr_done;

  int   total = 0;
  int   bad = 0;
  int   instr_id = 0;
  int   cycle_no = 0;
  cyc_t q[$];

  always #5 clk = ~clk;

  control_sequencer #(.BITS(32), .REGISTERS(16), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .IRVal(IRVal),
    .GPRin(GPRin), .GPRout(GPRout), .PCin(PCin), .IRin(IRin), .RYin(RYin), .RZin(RZin),
    .MARin(MARin), .HILOin(HILOin), .MDRin(MDRin), .OUTPUTin(OUTPUTin), .Read(Read),
    .Write(Write), .INPUTout(INPUTout), .MDRout(MDRout), .HILOout(HILOout), .RZout(RZout),
    .PCout(PCout), .BAout(BAout), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR),
    .SHL(SHL), .ROR(ROR), .ROL(ROL), .AND(AND), .OR(OR), .NEGATE(NEGATE), .NOT(NOT),
    .IncPC(IncPC), .halted(halted), .illegal(illegal), .instr_done(instr_done)
  );

  function automatic ctl_t sample();
    ctl_t s;
    s = '{gin: GPRin, gout: GPRout, pc_in: PCin, ir_in: IRin, ry_in: RYin, rz_in: RZin,
          mar_in: MARin, hilo_in: HILOin, mdr_in: MDRin, out_in: OUTPUTin, rd: Read, wr: Write,
          in_out: INPUTout, mdr_out: MDRout, hilo_out: HILOout, rz_out: RZout, pc_out: PCout,
          ba_out: BAout, add: ADD, sub: SUB, mul: MUL, div: DIV, shr: SHR, shl: SHL, ror: ROR,
          rol: ROL, and_: AND, or_: OR, neg: NEGATE, not_: NOT, inc_pc: IncPC,
          halted: halted, illegal: illegal, done: instr_done};
    return s;
  endfunction

  task automatic check(input string tag, input ctl_t exp);
    ctl_t obs;
    obs = sample();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] onehot(input int i);
    logic [15:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic ctl_t with_op(input ctl_t e, input logic [4:0] op);
    ctl_t r;
    r = e;
    case (op)
      5'd3:  r.add  = 1'b1;
      5'd4:  r.sub  = 1'b1;
      5'd5:  r.shr  = 1'b1;
      5'd6:  r.shl  = 1'b1;
      5'd7:  r.ror  = 1'b1;
      5'd8:  r.rol  = 1'b1;
      5'd9:  r.and_ = 1'b1;
      5'd10: r.or_  = 1'b1;
      5'd14: r.mul  = 1'b1;
      5'd15: r.div  = 1'b1;
      5'd16: r.neg  = 1'b1;
      5'd17: r.not_ = 1'b1;
      default: r = e;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mk(input int op, input int ra, input int rb, input int rc);
    return (32'(op) << 27) | (32'(ra) << 23) | (32'(rb) << 19) | (32'(rc) << 15);
  endfunction

  task automatic push(input logic rdy, input logic r, input logic [31:0] ir, input ctl_t e);
    cyc_t c;
    c.rdy = rdy; c.run = r; c.ir = ir; c.exp = e; c.id = instr_id;
    q.push_back(c);
  endtask

  function automatic logic rb1();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push_idle();
    push(rb1(), 1'b1, $urandom(), '0);
  endtask

  task automatic finish_instr(input ctl_t e, input logic [31:0] ir, input logic run_after);
    ctl_t d;
    d = e;
    d.done = 1'b1;
    push(rb1(), run_after, ir, d);
    if (!run_after) push_idle();
  endtask

  // Expand one instruction into its expected per-cycle strobe set.
  task automatic add_instr(input logic [31:0] ir, input int waits, input logic run_after);
    ctl_t e;
    logic [4:0] op;
    int ra, rb, rc, n4;
    bit is_alu, is_md, is_un;
    instr_id++;
    op = ir[31:27];
    ra = int'(ir[26:23]);
    rb = int'(ir[22:19]);
    rc = int'(ir[18:15]);
    is_alu = (op >= 5'd3) && (op <= 5'd10);
    is_md  = (op == 5'd14) || (op == 5'd15);
    is_un  = (op == 5'd16) || (op == 5'd17);
    n4 = is_md ? ((op == 5'd14) ? MULC : DIVC) : 1;

    e = '0; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.rz_in = 1;
    push(rb1(), rb1(), $urandom(), e);
    e = '0; e.rz_out = 1; e.pc_in = 1; e.rd = 1; e.mdr_in = 1;
    for (int w = 0; w < waits; w++) push(1'b0, rb1(), $urandom(), e);
    push(1'b1, rb1(), $urandom(), e);
    e = '0; e.mdr_out = 1; e.ir_in = 1;
    push(rb1(), rb1(), $urandom(), e);

    if (is_alu || is_md) begin
      e = '0; e.gout = onehot(rb); e.ry_in = 1;
      push(rb1(), rb1(), ir, e);
      for (int k = 0; k < n4; k++) begin
        e = '0; e.gout = onehot(rc); e.rz_in = 1; e = with_op(e, op);
        push(rb1(), rb1(), ir, e);
      end
      e = '0; e.rz_out = 1;
      if (is_md) e.hilo_in = 1; else e.gin = onehot(ra);
      finish_instr(e, ir, run_after);
    end else if (is_un) begin
      e = '0; e.gout = onehot(rb); e.rz_in = 1; e = with_op(e, op);
      push(rb1(), rb1(), ir, e);
      e = '0; e.rz_out = 1; e.gin = onehot(ra);
      finish_instr(e, ir, run_after);
    end else if (op == 5'd21) begin
      e = '0; e.in_out = 1; e.gin = onehot(ra);
      finish_instr(e, ir, run_after);
    end else if (op == 5'd22) begin
      e = '0; e.out_in = 1; e.gout = onehot(ra);
      finish_instr(e, ir, run_after);
    end else if (op == 5'd25) begin
      finish_instr('0, ir, run_after);
    end else if (op == 5'd26) begin
      push(rb1(), rb1(), ir, '0);
    end else begin
      e = '0; e.illegal = 1;
      finish_instr(e, ir, run_after);
    end
  endtask

  task automatic run_queue(input int n);
    cyc_t c;
    for (int k = 0; k < n && q.size() > 0; k++) begin
      c = q.pop_front();
      @(negedge clk);
      mem_ready = c.rdy;
      run       = c.run;
      IRVal     = c.ir;
      #1;
      cycle_no++;
      check($sformatf("instr%0d_cyc%0d", c.id, cycle_no), c.exp);
    end
  endtask

  logic [4:0] legal_ops [15] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                 5'd14, 5'd15, 5'd16, 5'd17, 5'd21, 5'd22, 5'd25};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl_t hz;
    logic [4:0] op;
    logic [31:0] ir;

    reset = 1'b1; run = 1'b1; IRVal = $urandom(); mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("reset_state", '0);
    reset = 1'b0;
    run   = 1'b0;

    push_idle();
    add_instr(32'h4A920000, 0, 1);
    add_instr(mk(3, 1, 2, 3), 3, 1);
    add_instr(mk(14, 0, 1, 2), 0, 1);
    add_instr(mk(16, 7, 9, 0), 1, 0);
    add_instr(mk(21, 12, 0, 0), 0, 1);
    add_instr(mk(22, 15, 0, 0), 2, 1);
    run_queue(100000);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 5'd0;
        for (int t = 0; t < 64; t++) begin
          op = 5'($urandom_range(0, 31));
          if (!(op inside {legal_ops, 5'd26})) break;
        end
        if (op inside {legal_ops, 5'd26}) op = 5'd31;
      end else begin
        op = legal_ops[$urandom_range(0, 14)];
      end
      ir = mk(int'(op), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15))
           | 32'($urandom_range(0, 32767));
      add_instr(ir, $urandom_range(0, 3), ($urandom_range(0, 3) != 0));
    end
    run_queue(100000);

    // Abort a divide in the middle of its T4 hold.
    add_instr(mk(15, 0, 3, 4), 0, 1);
    run_queue(6);
    hz = '0; hz.gout = onehot(4); hz.rz_in = 1; hz.div = 1;
    check("div_hold_before_reset", hz);
    reset = 1'b1;
    run   = 1'b0;
    #1 check("reset_mid_hold", '0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    push_idle();
    add_instr(mk(15, 0, 5, 6), 0, 1);
    add_instr(32'hF8000000, 0, 1);
    add_instr(32'hD0000000, 0, 1);
    hz = '0; hz.halted = 1;
    for (int i = 0; i < 10; i++) push(rb1(), rb1(), $urandom(), hz);
    run_queue(100000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
